hazard_stall_unit: RTL and testbench
====================================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-specifier width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, load-use stall length in cycles (legal 1..7).
REQ-003 SHALL have parameter CNT_W, default 16, stall-statistics counter width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ID_EX_MemRead  in  1  EX-stage instruction is a load.
REQ-007 SHALL have port ID_EX_RegisterRt  in  REG_ADDR_W  load destination register.
REQ-008 SHALL have port IF_ID_RegisterRs  in  REG_ADDR_W  decode source register 1.
REQ-009 SHALL have port IF_ID_RegisterRt  in  REG_ADDR_W  decode source register 2.
REQ-010 SHALL have port IF_ID_UsesRt  in  1  decode instruction reads Rt as a source.
REQ-011 SHALL have port branch_taken  in  1  EX-stage branch/jump resolved taken.
REQ-012 SHALL have port stat_clear  in  1  synchronous clear of stall_count.
REQ-013 SHALL have port control_flush  out  1  zero ID/EX control signals (insert bubble).
REQ-014 SHALL have port pc_freeze  out  1  hold PC.
REQ-015 SHALL have port IF_ID_freeze  out  1  hold IF/ID register.
REQ-016 SHALL have port IF_ID_flush  out  1  clear IF/ID register.
REQ-017 SHALL have port stall_active  out  1  FSM in STALL state.
REQ-018 SHALL have port stall_count  out  CNT_W  saturating count of cycles with pc_freeze high.

Function
REQ-019 SHALL define hazard = ID_EX_MemRead && ID_EX_RegisterRt != 0 && (ID_EX_RegisterRt == IF_ID_RegisterRs || (IF_ID_UsesRt && ID_EX_RegisterRt == IF_ID_RegisterRt)).
REQ-020 SHALL implement FSM states IDLE and STALL plus down-counter remain (3 bits).
REQ-021 In IDLE with hazard and no branch_taken, SHALL assert control_flush, pc_freeze, IF_ID_freeze combinationally in the same cycle.
REQ-022 In IDLE with hazard, SHALL go to STALL with remain = LOAD_LAT-2 when LOAD_LAT >= 2; with LOAD_LAT = 1 SHALL stay IDLE (single-cycle stall).
REQ-023 In STALL, SHALL assert control_flush, pc_freeze, IF_ID_freeze, stall_active regardless of current hazard inputs.
REQ-024 In STALL, SHALL decrement remain each cycle; SHALL return to IDLE on the cycle remain == 0, so total stall = exactly LOAD_LAT cycles.
REQ-025 branch_taken SHALL have priority: assert IF_ID_flush and control_flush, deassert pc_freeze and IF_ID_freeze, force next state IDLE (aborts any stall).
REQ-026 Without hazard, STALL or branch_taken, all control outputs SHALL be 0.
REQ-027 stall_count SHALL increment by 1 on each clock edge where pc_freeze is 1, saturating at all-ones.
REQ-028 stat_clear SHALL zero stall_count on the next edge; clear SHALL win over a simultaneous increment.
REQ-029 Register 0 as load destination SHALL never cause a stall.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, remain 0, stall_count 0.
REQ-031 During and after reset with no hazard, all control outputs and stall_active SHALL be 0; reset mid-STALL SHALL abort the stall immediately.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, STALL) and the LOAD_LAT legal range bound in shared package hazard_pkg.
REQ-033 SHALL instantiate one sub-module hazard_stat_counter (CNT_W-wide saturating counter with enable and synchronous clear) for stall_count.

Verification
REQ-034 LOAD_LAT=1, MemRead=1, EX Rt=5, ID Rs=5 -> freeze/flush high 1 cycle, stall_active never high, stall_count=1.
REQ-035 LOAD_LAT=3, MemRead=1, EX Rt=8, ID Rt=8, UsesRt=1, MemRead dropped next cycle -> freeze high 3 consecutive cycles, stall_active high cycles 2-3, stall_count=3.
REQ-036 EX Rt=0, ID Rs=0, MemRead=1 -> no outputs asserted; EX Rt=7, ID Rt=7, UsesRt=0 -> no stall.
REQ-037 LOAD_LAT=4, branch_taken=1 in second stall cycle -> IF_ID_flush=1, pc_freeze=0 that cycle, IDLE next cycle, stall_count=1.
REQ-038 stall_count=2^CNT_W-1 plus further stall -> stays all-ones; stat_clear with pc_freeze=1 -> 0.
REQ-039 rst_n low mid-STALL (LOAD_LAT=5) -> outputs drop immediately, stall_count=0, stall_active=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and bounds for the load-use hazard stall unit.
package hazard_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } stall_state_e;

   localparam int LOAD_LAT_MIN = 1;
   localparam int LOAD_LAT_MAX = 7;
   localparam int REMAIN_W     = 3;

   // Out-of-range stall lengths are pinned to the nearest legal value so the
   // 3-bit remain timer can never wrap.
   function automatic int clamp_load_lat(input int lat);
      if (lat < LOAD_LAT_MIN) return LOAD_LAT_MIN;
      if (lat > LOAD_LAT_MAX) return LOAD_LAT_MAX;
      return lat;
   endfunction

endpackage

// File: rtl/hazard_stat_counter.sv
// Saturating event counter with enable and synchronous clear (clear has priority).
module hazard_stat_counter
   import hazard_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use hazard detection and pipeline stall/flush sequencing.
//   state | meaning
//   IDLE  | no stall in progress; a fresh hazard freezes the pipe this cycle
//   STALL | additional load-use stall cycles, counted down by remain
module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int LOAD_LAT   = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ID_EX_MemRead,
   input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRt,
   input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs,
   input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt,
   input  logic                  IF_ID_UsesRt,
   input  logic                  branch_taken,
   input  logic                  stat_clear,
   output logic                  control_flush,
   output logic                  pc_freeze,
   output logic                  IF_ID_freeze,
   output logic                  IF_ID_flush,
   output logic                  stall_active,
   output logic [CNT_W-1:0]      stall_count
);

   localparam int                  LAT_EFF     = clamp_load_lat(LOAD_LAT);
   localparam bit                  MULTI_CYCLE = (LAT_EFF >= 2);
   localparam logic [REMAIN_W-1:0] REMAIN_INIT =
      MULTI_CYCLE ? REMAIN_W'(LAT_EFF - 2) : '0;

   stall_state_e        state;
   logic [REMAIN_W-1:0] remain;
   logic                hazard;
   logic                stall_req;

   assign hazard = ID_EX_MemRead
                && (ID_EX_RegisterRt != '0)
                && ((ID_EX_RegisterRt == IF_ID_RegisterRs)
                    || (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));

   assign stall_req    = (state == STALL) || hazard;
   assign stall_active = (state == STALL);

   // A taken branch squashes the stalled instruction, so it aborts any stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         remain <= '0;
      end else if (branch_taken) begin
         state  <= IDLE;
         remain <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hazard && MULTI_CYCLE) begin
                  state  <= STALL;
                  remain <= REMAIN_INIT;
               end
            end
            STALL: begin
               if (remain == '0) begin
                  state <= IDLE;
               end else begin
                  remain <= remain - 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               remain <= '0;
            end
         endcase
      end
   end

   always_comb begin
      control_flush = 1'b0;
      pc_freeze     = 1'b0;
      IF_ID_freeze  = 1'b0;
      IF_ID_flush   = 1'b0;
      if (branch_taken) begin
         control_flush = 1'b1;
         IF_ID_flush   = 1'b1;
      end else if (stall_req) begin
         control_flush = 1'b1;
         pc_freeze     = 1'b1;
         IF_ID_freeze  = 1'b1;
      end
   end

   hazard_stat_counter #(
      .CNT_W (CNT_W)
   ) u_stat (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pc_freeze),
      .clr   (stat_clear),
      .count (stall_count)
   );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: four instances (LOAD_LAT 1/3/4/5) driven from shared inputs.
module tb_hazard_stall_unit;

   localparam int N_DUT = 4;
   localparam int LAT [N_DUT] = '{1, 3, 4, 5};

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mem_read;
   logic [4:0] ex_rt;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       uses_rt;
   logic       branch_taken;
   logic       stat_clear;

   logic        cf [N_DUT];
   logic        pf [N_DUT];
   logic        ff [N_DUT];
   logic        fl [N_DUT];
   logic        sa [N_DUT];
   logic [15:0] sc [N_DUT];

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   // Instance 0 uses a 3-bit counter so saturation is reachable quickly.
   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      localparam int CW = (g == 0) ? 3 : 16;
      logic [CW-1:0] cnt;
      assign sc[g] = 16'(cnt);
      hazard_stall_unit #(
         .REG_ADDR_W (5),
         .LOAD_LAT   (LAT[g]),
         .CNT_W      (CW)
      ) u_dut (
         .clk              (clk),
         .rst_n            (rst_n),
         .ID_EX_MemRead    (mem_read),
         .ID_EX_RegisterRt (ex_rt),
         .IF_ID_RegisterRs (id_rs),
         .IF_ID_RegisterRt (id_rt),
         .IF_ID_UsesRt     (uses_rt),
         .branch_taken     (branch_taken),
         .stat_clear       (stat_clear),
         .control_flush    (cf[g]),
         .pc_freeze        (pf[g]),
         .IF_ID_freeze     (ff[g]),
         .IF_ID_flush      (fl[g]),
         .stall_active     (sa[g]),
         .stall_count      (cnt)
      );
   end

   typedef struct {
      logic       mem_read;
      logic [4:0] ex_rt;
      logic [4:0] id_rs;
      logic [4:0] id_rt;
      logic       uses_rt;
      logic       branch;
      logic       exp_cf;
      logic       exp_pf;
      logic       exp_ff;
      logic       exp_fl;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_ctrl(input string name, input int d,
                             input logic ecf, input logic epf, input logic eff,
                             input logic efl, input logic esa);
      check({name, ".control_flush"}, 16'(cf[d]), 16'(ecf));
      check({name, ".pc_freeze"},     16'(pf[d]), 16'(epf));
      check({name, ".IF_ID_freeze"},  16'(ff[d]), 16'(eff));
      check({name, ".IF_ID_flush"},   16'(fl[d]), 16'(efl));
      check({name, ".stall_active"},  16'(sa[d]), 16'(esa));
   endtask

   task automatic idle_inputs();
      mem_read     = 1'b0;
      ex_rt        = '0;
      id_rs        = '0;
      id_rt        = '0;
      uses_rt      = 1'b0;
      branch_taken = 1'b0;
      stat_clear   = 1'b0;
   endtask

   task automatic load_use(input logic [4:0] rt_ex, input logic [4:0] rs_id,
                           input logic [4:0] rt_id, input logic use_rt);
      mem_read = 1'b1;
      ex_rt    = rt_ex;
      id_rs    = rs_id;
      id_rt    = rt_id;
      uses_rt  = use_rt;
   endtask

   // Leaves time at posedge+1 with reset released.
   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Advance to the next posedge+1; inputs are driven there, checks at +4.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 5'd7,  5'd0,  5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 5'd8,  5'd0,  5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 5'd31, 5'd31, 5'd3,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{1'b1, 5'd9,  5'd10, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{1'b1, 5'd0,  5'd3,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset values, observed while reset is held.
      idle_inputs();
      rst_n = 1'b0;
      #3;
      for (int d = 0; d < N_DUT; d++) begin
         check_ctrl($sformatf("reset[%0d]", d), d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         check($sformatf("reset[%0d].stall_count", d), sc[d], 16'd0);
      end
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      // Combinational detect/priority table on the LOAD_LAT=1 instance.
      for (int i = 0; i < 10; i++) begin
         mem_read     = vecs[i].mem_read;
         ex_rt        = vecs[i].ex_rt;
         id_rs        = vecs[i].id_rs;
         id_rt        = vecs[i].id_rt;
         uses_rt      = vecs[i].uses_rt;
         branch_taken = vecs[i].branch;
         #3;
         check_ctrl($sformatf("vec%0d", i), 0, vecs[i].exp_cf, vecs[i].exp_pf,
                    vecs[i].exp_ff, vecs[i].exp_fl, 1'b0);
         next_cycle();
      end

      // LOAD_LAT=1: one-cycle stall, never enters STALL.
      do_reset();
      load_use(5'd5, 5'd5, 5'd0, 1'b0);
      #3 check_ctrl("lat1.c1", 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      next_cycle();
      mem_read = 1'b0;
      #3 check_ctrl("lat1.c2", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("lat1.stall_count", sc[0], 16'd1);

      // LOAD_LAT=3 via Rt: stall holds after the hazard goes away.
      do_reset();
      load_use(5'd8, 5'd0, 5'd8, 1'b1);
      #3 check_ctrl("lat3.c1", 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      next_cycle();
      mem_read = 1'b0;
      #3 check_ctrl("lat3.c2", 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      next_cycle();
      #3 check_ctrl("lat3.c3", 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      next_cycle();
      #3 check_ctrl("lat3.c4", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("lat3.stall_count", sc[1], 16'd3);

      // LOAD_LAT=4: taken branch in the second stall cycle aborts the stall.
      do_reset();
      load_use(5'd12, 5'd12, 5'd0, 1'b0);
      #3 check_ctrl("lat4.c1", 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      next_cycle();
      mem_read     = 1'b0;
      branch_taken = 1'b1;
      #3 check_ctrl("lat4.branch", 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      next_cycle();
      branch_taken = 1'b0;
      #3 check_ctrl("lat4.after", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("lat4.stall_count", sc[2], 16'd1);

      // LOAD_LAT=5: async reset in the middle of a stall.
      do_reset();
      load_use(5'd3, 5'd3, 5'd0, 1'b0);
      next_cycle();
      mem_read = 1'b0;
      #3 check_ctrl("lat5.stall", 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1 check_ctrl("lat5.rst", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("lat5.rst.stall_count", sc[3], 16'd0);
      next_cycle();
      rst_n = 1'b1;
      #3 check_ctrl("lat5.post", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();

      // Saturation and clear-over-increment on the 3-bit counter.
      do_reset();
      load_use(5'd5, 5'd5, 5'd0, 1'b0);
      for (int c = 0; c < 9; c++) next_cycle();
      #3 check("sat.stall_count", sc[0], 16'd7);
      check("sat.pc_freeze", 16'(pf[0]), 16'd1);
      stat_clear = 1'b1;
      next_cycle();
      stat_clear = 1'b0;
      #3 check("clr.stall_count", sc[0], 16'd0);
      next_cycle();
      #3 check("resume.stall_count", sc[0], 16'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
